// File: rtl/rst_seq_multi.sv
// rst_seq_multi: lock-synchronised, debounced, staggered multi-domain reset sequencer
// with software warm reset and a saturating lock-loss counter.
module rst_seq_multi #(
   parameter int N_CH           = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int LOCK_FILTER    = 16,
   parameter int DELAY_CYCLES   = 100,
   parameter int STAGGER_CYCLES = 16,
   parameter int SW_HOLD_CYCLES = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lock_in,
   input  logic            sw_reset_req,
   output logic [N_CH-1:0] reset_n_out,
   output logic            ready,
   output logic [7:0]      lock_loss_cnt
);
   localparam int M1  = LOCK_FILTER > DELAY_CYCLES ? LOCK_FILTER : DELAY_CYCLES;
   localparam int M2  = STAGGER_CYCLES > SW_HOLD_CYCLES ? STAGGER_CYCLES : SW_HOLD_CYCLES;
   localparam int CW  = $clog2((M1 > M2 ? M1 : M2) + 1);
   localparam int CHW = $clog2(N_CH) + 1;

   typedef enum logic [2:0] {WAIT_LOCK, FILTER, DELAY, RELEASE, RUN, SW_HOLD} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [CHW-1:0]         ch, ch_nxt;
   logic [N_CH-1:0]        rstn_nxt;
   logic [7:0]             llc_nxt;
   logic                   lock_s, lock_loss, f_done, d_done, s_done, h_done;

   assign lock_s    = sync[SYNC_STAGES-1];
   assign f_done    = cnt == CW'(LOCK_FILTER - 1);
   assign d_done    = cnt == CW'(DELAY_CYCLES - 1);
   assign s_done    = cnt == CW'(STAGGER_CYCLES - 1);
   assign h_done    = cnt == CW'(SW_HOLD_CYCLES - 1);
   assign lock_loss = !lock_s && (state == DELAY || state == RELEASE || state == RUN || state == SW_HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync          <= '0;
         state         <= WAIT_LOCK;
         cnt           <= '0;
         ch            <= '0;
         reset_n_out   <= '0;
         ready         <= 1'b0;
         lock_loss_cnt <= '0;
      end else begin
         sync          <= {sync[SYNC_STAGES-2:0], lock_in};
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         ch            <= ch_nxt;
         reset_n_out   <= rstn_nxt;
         ready         <= state_nxt == RUN;
         lock_loss_cnt <= llc_nxt;
      end
   end

   // Lock loss overrides every other transition, including a coincident sw request.
   always_comb begin
      state_nxt = state;
      if (lock_loss)
         state_nxt = WAIT_LOCK;
      else
         case (state)
            WAIT_LOCK: state_nxt = lock_s ? FILTER : WAIT_LOCK;
            FILTER:    state_nxt = !lock_s ? WAIT_LOCK : f_done ? DELAY : FILTER;
            DELAY:     state_nxt = d_done ? (N_CH == 1 ? RUN : RELEASE) : DELAY;
            RELEASE:   state_nxt = (s_done && ch == CHW'(N_CH - 1)) ? RUN : RELEASE;
            RUN:       state_nxt = sw_reset_req ? SW_HOLD : RUN;
            SW_HOLD:   state_nxt = h_done ? DELAY : SW_HOLD;
            default:   state_nxt = WAIT_LOCK;
         endcase
   end

   always_comb begin
      cnt_nxt  = (state_nxt != state || state == WAIT_LOCK || state == RUN || (state == RELEASE && s_done))
                 ? '0 : cnt + CW'(1);
      ch_nxt   = lock_loss ? '0
               : (state == DELAY && d_done) ? CHW'(1)
               : (state == RELEASE && s_done) ? ch + CHW'(1) : ch;
      rstn_nxt = (lock_loss || (state == RUN && sw_reset_req)) ? '0
               : (state == DELAY && d_done) ? reset_n_out | N_CH'(1)
               : (state == RELEASE && s_done) ? reset_n_out | (N_CH'(1) << ch) : reset_n_out;
      llc_nxt  = (lock_loss && (state == RELEASE || state == RUN) && lock_loss_cnt != 8'hff)
                 ? lock_loss_cnt + 8'd1 : lock_loss_cnt;
   end
endmodule
